ctrl_sequencer: RTL and testbench
=================================

// Module: ctrl_sequencer
// PURPOSE
//  Multi-cycle control sequencer directly upstream of the register-file/ALU/memory datapath.
//  Accepts one 32-bit instruction per valid/ready handshake and decodes it.
//  Drives the datapath controls (r1, r2, wr_addr, ALUc, regw, memr, memw) as registered outputs.
//  Every control is stable for a full cycle before the datapath samples it on the next rising
//  edge, so no control signal ever changes on the same edge that consumes it.
// PARAMETERS
//  ALU_ADD   5'b00010  ALUc code used for load/store address calculation
//  CNT_W     16        width of retired-instruction counter
// PORTS
//  clk          in   1      single system clock, all state on rising edge
//  reset        in   1      asynchronous, active-low reset (0 = reset)
//  instr_valid  in   1      upstream has an instruction on instr
//  instr        in   32     [31:26] op, [25:21] rs, [20:16] rt, [15:11] rd, [4:0] funct
//  instr_ready  out  1      sequencer can accept (high only in IDLE)
//  r1           out  5      read address 1 (rs)
//  r2           out  5      read address 2 (rt)
//  wr_addr      out  5      write-back address (rd for R-type, rt for LOAD)
//  ALUc         out  5      ALU control
//  regw         out  1      register write enable, one-cycle pulse
//  memr         out  1      memory read enable
//  memw         out  1      memory write enable, one-cycle pulse
//  busy         out  1      high in any state other than IDLE
//  done         out  1      one-cycle pulse in the first IDLE cycle after completion
//  illegal      out  1      one-cycle pulse: undefined opcode was dropped
//  retired      out  CNT_W  count of completed legal instructions, wraps to 0
// BEHAVIOUR
//  Reset (reset=0, asynchronous): state=IDLE.
//   - All outputs 0 except instr_ready=1; retired=0.
//   - Reset asserted mid-instruction aborts it; no regw/memw is issued afterwards.
//  Opcodes:
//   - 6'h00 R-type: ALUc=funct[4:0], wr_addr=rd.
//   - 6'h01 LOAD: ALUc=ALU_ADD, wr_addr=rt.
//   - 6'h02 STORE: ALUc=ALU_ADD.
//   - 6'h03 NOP.
//   - any other opcode is illegal.
//  States: IDLE, DECODE, EXEC, MEM, WB (encoding held in package).
//  Transitions:
//   - IDLE -valid&ready-> DECODE. The instruction is latched; r1/r2/wr_addr/ALUc are loaded
//     on this edge and held until the next accept.
//   - DECODE: NOP -> IDLE (done=1). Illegal -> IDLE (illegal=1, no done, retired unchanged).
//     Otherwise -> EXEC.
//   - EXEC (ALU evaluates): R-type -> WB; LOAD/STORE -> MEM.
//   - MEM: LOAD asserts memr=1 -> WB. STORE asserts memw=1 for this cycle only -> IDLE.
//   - WB: regw=1 for this cycle only; memr stays 1 for LOAD so dout is valid -> IDLE.
//  Latency from the accept edge to the done pulse:
//   - R-type 3 cycles, LOAD 4, STORE 3, NOP 1.
//  retired increments on the same edge that sets done (NOP included); wraps 2^CNT_W-1 -> 0.
//  instr_valid while busy is ignored; the instruction is not consumed (ready=0).
//  Back-to-back: done and instr_ready are both high in the IDLE cycle, so the next accept can
//  occur on that cycle's edge.
//  regw, memr and memw are never high together in any cycle except LOAD's WB (regw & memr).
//  Address outputs never change while regw or memw is high.
// STRUCTURE
//  Package ctrl_pkg: state typedef/localparams, opcode constants (OP_RTYPE, OP_LOAD,
//  OP_STORE, OP_NOP), ALU_ADD default.
//  Optional sub-module instr_decode: combinational op/field decode -> ALUc, wr_addr, class
//  flags. The FSM and output registers stay in ctrl_sequencer.
// TESTING
//  1 reset=0 mid-LOAD (in MEM): outputs 0 and ready=1 immediately; no regw afterwards;
//    retired unchanged.
//  2 R-type op=0 rs=1 rt=2 rd=3 funct=5'h04:
//    r1=1, r2=2, ALUc=4; regw pulses in WB with wr_addr=3; done 3 cycles after accept.
//  3 LOAD rs=0 rt=1: ALUc=2; memr high for MEM+WB; regw one cycle, wr_addr=1; done at 4.
//  4 STORE: memw exactly one cycle; regw never high; done at 3.
//    instr_valid held during busy -> ready=0, accepted only after done.
//  5 opcode 6'h3F: illegal pulse, no done, retired unchanged.
//    Next NOP: done 1 cycle after accept, retired+1.
//  6 preload retired to 16'hFFFF via 65535 NOPs: next NOP wraps it to 0.
//    Back-to-back NOPs are accepted every 2 cycles.

Source files
------------

// File: rtl/ctrl_sequencer_pkg.sv
// Shared types and constants for the control sequencer: FSM states, instruction
// classes, opcode values and the decoded-instruction record.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        CL_RTYPE   = 3'd0,
        CL_LOAD    = 3'd1,
        CL_STORE   = 3'd2,
        CL_NOP     = 3'd3,
        CL_ILLEGAL = 3'd4
    } iclass_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LOAD  = 6'h01;
    localparam logic [5:0] OP_STORE = 6'h02;
    localparam logic [5:0] OP_NOP   = 6'h03;

    localparam logic [4:0] ALU_ADD_DEF = 5'b00010;
    localparam int         CNT_W_DEF   = 16;

    typedef struct packed {
        iclass_e    cls;
        logic [4:0] r1;
        logic [4:0] r2;
        logic [4:0] wr_addr;
        logic [4:0] aluc;
    } dec_t;

endpackage

// File: rtl/ctrl_sequencer_decode.sv
// Combinational instruction decode: splits the word into register fields, picks the
// ALU code and write-back address, and classifies the opcode.
module instr_decode
    import ctrl_pkg::*;
#(
    parameter logic [4:0] ALU_ADD = ALU_ADD_DEF
) (
    input  logic [31:0] instr_i,
    output dec_t        dec_o
);

    logic [5:0] op;
    logic [4:0] rs, rt, rd, funct;
    logic       unused_shamt;

    assign op    = instr_i[31:26];
    assign rs    = instr_i[25:21];
    assign rt    = instr_i[20:16];
    assign rd    = instr_i[15:11];
    assign funct = instr_i[4:0];

    // Bits [10:5] carry no meaning for this datapath.
    assign unused_shamt = ^instr_i[10:5];

    always_comb begin
        dec_o    = '0;
        dec_o.r1 = rs;
        dec_o.r2 = rt;
        case (op)
            OP_RTYPE: begin
                dec_o.cls     = CL_RTYPE;
                dec_o.aluc    = funct;
                dec_o.wr_addr = rd;
            end
            OP_LOAD: begin
                dec_o.cls     = CL_LOAD;
                dec_o.aluc    = ALU_ADD;
                dec_o.wr_addr = rt;
            end
            OP_STORE: begin
                dec_o.cls  = CL_STORE;
                dec_o.aluc = ALU_ADD;
            end
            OP_NOP:  dec_o.cls = CL_NOP;
            default: dec_o.cls = CL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle control sequencer: accepts one instruction per handshake and walks it
// through DECODE/EXEC/MEM/WB, driving registered datapath controls.
module ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter logic [4:0] ALU_ADD = ALU_ADD_DEF,
    parameter int         CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [31:0]      instr,
    output logic             instr_ready,
    output logic [4:0]       r1,
    output logic [4:0]       r2,
    output logic [4:0]       wr_addr,
    output logic [4:0]       ALUc,
    output logic             regw,
    output logic             memr,
    output logic             memw,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_e           state_q, state_d;
    iclass_e          cls_q;
    dec_t             dec;
    logic             accept;

    logic [4:0]       r1_q, r2_q, wa_q, aluc_q;
    logic             ready_q, busy_q, regw_q, memr_q, memw_q, done_q, ill_q;
    logic             ready_d, busy_d, regw_d, memr_d, memw_d, done_d, ill_d;
    logic [CNT_W-1:0] ret_q;

    instr_decode #(.ALU_ADD(ALU_ADD)) u_dec (
        .instr_i (instr),
        .dec_o   (dec)
    );

    assign accept = instr_valid && (state_q == ST_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = ST_DECODE;
            ST_DECODE: begin
                if (cls_q == CL_NOP || cls_q == CL_ILLEGAL) state_d = ST_IDLE;
                else                                        state_d = ST_EXEC;
            end
            ST_EXEC:   state_d = (cls_q == CL_RTYPE) ? ST_WB : ST_MEM;
            ST_MEM:    state_d = (cls_q == CL_LOAD) ? ST_WB : ST_IDLE;
            ST_WB:     state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Controls are computed for the state being entered and registered, so every
    // control is already stable for the whole cycle the datapath spends in that state.
    always_comb begin
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
        regw_d  = (state_d == ST_WB);
        memr_d  = (cls_q == CL_LOAD) && (state_d == ST_MEM || state_d == ST_WB);
        memw_d  = (cls_q == CL_STORE) && (state_d == ST_MEM);
        done_d  = (state_q != ST_IDLE) && (state_d == ST_IDLE) && (cls_q != CL_ILLEGAL);
        ill_d   = (state_q == ST_DECODE) && (cls_q == CL_ILLEGAL);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            regw_q  <= 1'b0;
            memr_q  <= 1'b0;
            memw_q  <= 1'b0;
            done_q  <= 1'b0;
            ill_q   <= 1'b0;
            ret_q   <= '0;
        end else begin
            ready_q <= ready_d;
            busy_q  <= busy_d;
            regw_q  <= regw_d;
            memr_q  <= memr_d;
            memw_q  <= memw_d;
            done_q  <= done_d;
            ill_q   <= ill_d;
            if (done_d) ret_q <= ret_q + CNT_W'(1);
        end
    end

    // Address/ALU fields only move on accept, so they are frozen across regw/memw.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cls_q  <= CL_NOP;
            r1_q   <= '0;
            r2_q   <= '0;
            wa_q   <= '0;
            aluc_q <= '0;
        end else if (accept) begin
            cls_q  <= dec.cls;
            r1_q   <= dec.r1;
            r2_q   <= dec.r2;
            wa_q   <= dec.wr_addr;
            aluc_q <= dec.aluc;
        end
    end

    assign instr_ready = ready_q;
    assign busy        = busy_q;
    assign regw        = regw_q;
    assign memr        = memr_q;
    assign memw        = memw_q;
    assign done        = done_q;
    assign illegal     = ill_q;
    assign retired     = ret_q;
    assign r1          = r1_q;
    assign r2          = r2_q;
    assign wr_addr     = wa_q;
    assign ALUc        = aluc_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: a cycle-count model of each instruction's
// lifetime checked every cycle, plus directed scenarios with literal expectations.
module tb_ctrl_sequencer;

    localparam int         TCW  = 10;  // narrow counter keeps the wrap reachable quickly
    localparam logic [4:0] AADD = 5'b00010;
    localparam logic [31:0] I_R     = 32'h0022_1804;  // op0 rs1 rt2 rd3 funct4
    localparam logic [31:0] I_LOAD  = 32'h0401_0000;  // op1 rs0 rt1
    localparam logic [31:0] I_STORE = 32'h0864_0000;  // op2 rs3 rt4
    localparam logic [31:0] I_NOP   = 32'h0C00_0000;
    localparam logic [31:0] I_ILL   = 32'hFC00_0000;

    logic clk = 1'b0, rst_n = 1'b0, instr_valid = 1'b0;
    logic [31:0] instr = '0;
    logic instr_ready, regw, memr, memw, busy, done, illegal;
    logic [4:0] r1, r2, wr_addr, ALUc;
    logic [TCW-1:0] retired;
    int checks = 0, errors = 0;
    bit cmp_en = 0;

    always #5 clk = ~clk;

    ctrl_sequencer #(.CNT_W(TCW)) dut (
        .clk(clk), .reset(rst_n), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .r1(r1), .r2(r2), .wr_addr(wr_addr), .ALUc(ALUc),
        .regw(regw), .memr(memr), .memw(memw), .busy(busy), .done(done),
        .illegal(illegal), .retired(retired)
    );

    // Model: an accepted instruction is busy for lat cycles (indexed j from the accept
    // edge), then ends with done (or illegal) in the following cycle.
    logic m_busy, m_done, m_ill;
    int   m_j, m_lat, m_cls;
    logic [4:0] m_r1, m_r2, m_wa, m_alu;
    logic [TCW-1:0] m_ret;

    function automatic int cls_of(input logic [5:0] op);
        return (op <= 6'd3) ? int'(op) : 4;
    endfunction

    function automatic int lat_of(input int c);
        case (c)
            0: return 3;
            1: return 4;
            2: return 3;
            default: return 1;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 0; m_done <= 0; m_ill <= 0; m_j <= 0; m_lat <= 1; m_cls <= 3;
            m_r1 <= 0; m_r2 <= 0; m_wa <= 0; m_alu <= 0; m_ret <= 0;
        end else begin
            m_done <= 0;
            m_ill  <= 0;
            if (m_busy) begin
                m_j <= m_j + 1;
                if (m_j + 1 == m_lat) begin
                    m_busy <= 0;
                    if (m_cls == 4) m_ill <= 1;
                    else begin
                        m_done <= 1;
                        m_ret  <= m_ret + TCW'(1);
                    end
                end
            end else if (instr_valid) begin
                m_busy <= 1;
                m_j    <= 0;
                m_cls  <= cls_of(instr[31:26]);
                m_lat  <= lat_of(cls_of(instr[31:26]));
                m_r1   <= instr[25:21];
                m_r2   <= instr[20:16];
                m_wa   <= (instr[31:26] == 6'd0) ? instr[15:11] :
                          (instr[31:26] == 6'd1) ? instr[20:16] : 5'd0;
                m_alu  <= (instr[31:26] == 6'd0) ? instr[4:0] :
                          (instr[31:26] == 6'd1 || instr[31:26] == 6'd2) ? AADD : 5'd0;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic issue(input logic [31:0] ins);
        bit ok = 0;
        @(negedge clk);
        instr = ins;
        instr_valid = 1;
        for (int k = 0; k < 40; k++) begin
            if (instr_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        instr_valid = 0;
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    // Issue one instruction, then watch it to its done/illegal cycle.
    task automatic run(input logic [31:0] ins, output int lat, output int ndone,
                       output int nregw, output int nmemr, output int nmemw,
                       output logic [4:0] wa, output bit ill, output logic [14:0] flds);
        lat = -1; ndone = 0; nregw = 0; nmemr = 0; nmemw = 0; wa = 0; ill = 0;
        issue(ins);
        flds = {r1, r2, ALUc};
        for (int j = 0; j < 16; j++) begin
            if (regw) begin nregw++; wa = wr_addr; end
            if (memr) nmemr++;
            if (memw) nmemw++;
            if (done) begin ndone++; lat = j; break; end
            if (illegal) begin ill = 1; lat = j; break; end
            @(negedge clk);
        end
    endtask

    logic [36:0] e_vec, a_vec;
    int lat, nd, nrw, nmr, nmw, nr0, last, gap;
    logic [4:0] wa;
    bit ill, wrapped;
    logic [14:0] f;
    logic [TCW-1:0] ret0, prev;

    initial begin
        #12;
        chk("reset_ctrl", {instr_ready, busy, regw, memr, memw, done, illegal}, 7'b1000000);
        chk("reset_fields", {r1, r2, wr_addr, ALUc}, 20'h0);
        chk("reset_retired", retired, 0);
        @(negedge clk);
        rst_n = 1;
        cmp_en = 1;
        fork
            forever begin
                @(negedge clk);
                if (cmp_en) begin
                    e_vec = {~m_busy, m_busy,
                             m_busy && ((m_cls == 0 && m_j == 2) || (m_cls == 1 && m_j == 3)),
                             m_busy && m_cls == 1 && (m_j == 2 || m_j == 3),
                             m_busy && m_cls == 2 && m_j == 2,
                             m_done, m_ill, m_r1, m_r2, m_wa, m_alu, m_ret};
                    a_vec = {instr_ready, busy, regw, memr, memw, done, illegal,
                             r1, r2, wr_addr, ALUc, retired};
                    chk("cycle", 64'(a_vec), 64'(e_vec));
                end
            end
        join_none

        // Abort a LOAD while it sits in MEM.
        issue(I_LOAD);
        @(negedge clk);
        @(negedge clk);
        chk("abort_in_mem", memr, 1);
        #2 rst_n = 0;
        #1;
        chk("abort_ctrl", {instr_ready, busy, regw, memr, memw, done, illegal}, 7'b1000000);
        chk("abort_retired", retired, 0);
        @(negedge clk);
        rst_n = 1;
        nrw = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (regw || memw) nrw++;
        end
        chk("abort_no_write", nrw, 0);

        // R-type.
        run(I_R, lat, nd, nrw, nmr, nmw, wa, ill, f);
        chk("r_fields", f, {5'd1, 5'd2, 5'd4});
        chk("r_latency", lat, 3);
        chk("r_regw", nrw, 1);
        chk("r_wr_addr", wa, 3);
        chk("r_no_mem", nmr + nmw, 0);
        chk("r_retired", retired, 1);

        // LOAD.
        run(I_LOAD, lat, nd, nrw, nmr, nmw, wa, ill, f);
        chk("ld_alu", f[4:0], 2);
        chk("ld_latency", lat, 4);
        chk("ld_memr_cycles", nmr, 2);
        chk("ld_regw", nrw, 1);
        chk("ld_wr_addr", wa, 1);

        // STORE with a NOP held on valid while busy.
        @(negedge clk);
        chk("st_ready", instr_ready, 1);
        instr = I_STORE;
        instr_valid = 1;
        @(negedge clk);
        instr = I_NOP;
        lat = -1; nr0 = 0; nmw = 0; nrw = 0;
        for (int j = 0; j < 16; j++) begin
            if (!instr_ready) nr0++;
            if (memw) nmw++;
            if (regw) nrw++;
            if (done) begin lat = j; break; end
            @(negedge clk);
        end
        chk("st_latency", lat, 3);
        chk("st_memw", nmw, 1);
        chk("st_no_regw", nrw, 0);
        chk("st_not_ready", nr0, 3);
        chk("st_done_ready", instr_ready, 1);
        @(negedge clk);
        chk("held_accept", busy, 1);
        instr_valid = 0;
        @(negedge clk);
        chk("held_nop_done", done, 1);

        // Illegal opcode, then NOP.
        ret0 = retired;
        run(I_ILL, lat, nd, nrw, nmr, nmw, wa, ill, f);
        chk("ill_pulse", ill, 1);
        chk("ill_latency", lat, 1);
        chk("ill_no_done", nd, 0);
        chk("ill_retired", retired, ret0);
        run(I_NOP, lat, nd, nrw, nmr, nmw, wa, ill, f);
        chk("nop_latency", lat, 1);
        chk("nop_retired", retired, ret0 + TCW'(1));

        // Back-to-back NOPs up to and across the counter wrap.
        @(negedge clk);
        instr = I_NOP;
        instr_valid = 1;
        last = -1; gap = 0; wrapped = 0; prev = retired;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (done) begin
                if (last >= 0) gap = c - last;
                last = c;
                if (prev == {TCW{1'b1}}) begin
                    chk("wrap_value", retired, 0);
                    wrapped = 1;
                    break;
                end
                prev = retired;
            end
        end
        chk("wrap_reached", wrapped, 1);
        chk("b2b_gap", gap, 2);
        @(negedge clk);
        instr_valid = 0;
        repeat (3) @(negedge clk);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            instr_valid = ($urandom_range(0, 3) != 0);
            instr = $urandom;
            if ($urandom_range(0, 9) < 8) instr[31:26] = 6'($urandom_range(0, 3));
        end
        instr_valid = 0;
        repeat (6) @(negedge clk);
        cmp_en = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
